// File: rtl/conv_cfg_pkg.sv
// Shared definitions for the convolution filter configuration controller:
// register map, FSM state encoding and the identity-kernel reset constants.
package conv_cfg_pkg;

  localparam int unsigned ADDR_COEF0 = 0;
  localparam int unsigned ADDR_DIV   = 9;
  localparam int unsigned ADDR_BIAS  = 10;
  localparam int unsigned ADDR_CTRL  = 11;

  localparam int unsigned NUM_TAPS   = 9;

  // Identity kernel: only the centre tap (row 1, col 1) is 1, the divisor is 1 and the bias is 0.
  localparam int unsigned IDENT_TAP  = 4;
  localparam int          IDENT_DIV  = 1;
  localparam logic [7:0]  IDENT_BIAS = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/frame_tracker.sv
// Follows a valid/sop/eop pixel stream and reports frame occupancy, a wrapping
// count of completed frames, and the qualified sop/eop beats.
module frame_tracker #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 sop,
  input  logic                 eop,
  output logic                 in_frame,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 sop_beat,
  output logic                 eop_beat
);

  assign sop_beat = valid & sop;
  assign eop_beat = valid & eop;

  // eop wins over sop so a single-pixel frame leaves in_frame low
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame  <= 1'b0;
      frame_cnt <= '0;
    end else if (eop_beat) begin
      in_frame  <= 1'b0;
      frame_cnt <= frame_cnt + 1'b1;
    end else if (sop_beat) begin
      in_frame  <= 1'b1;
    end
  end

endmodule

// File: rtl/conv_filter_cfg_ctrl.sv
// Shadow/active kernel register file for the RGB 3x3 convolution filter. A commit
// copies the shadow set to the active outputs only between frames.
module conv_filter_cfg_ctrl
  import conv_cfg_pkg::*;
#(
  parameter int COEF_WIDTH = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic                         rd_en_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [7:0]                   wr_data_i,
  output logic [7:0]                   rd_data_o,
  output logic                         rd_valid_o,
  output logic                         wr_err_o,
  input  logic                         valid_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  output logic signed [COEF_WIDTH-1:0] coef_o [3][3],
  output logic signed [COEF_WIDTH-1:0] div_coef_o,
  output logic [7:0]                   bias_factor_o,
  output logic                         pending_o,
  output logic                         commit_done_o,
  output logic                         cfg_err_o,
  output logic                         in_frame_o,
  output logic [CNT_WIDTH-1:0]         frame_cnt_o
);

  function automatic logic signed [COEF_WIDTH-1:0] ident_coef(input int unsigned idx);
    return (idx == IDENT_TAP) ? COEF_WIDTH'(1) : '0;
  endfunction

  function automatic logic [7:0] sext8(input logic signed [COEF_WIDTH-1:0] c);
    logic signed [7:0] r;
    r = 8'(c);
    return r;
  endfunction

  cfg_state_t                   state, state_nxt;
  logic signed [COEF_WIDTH-1:0] shadow_coef [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_div;
  logic [7:0]                   shadow_bias;
  logic                         sop_beat, eop_beat;
  logic                         commit_wr, shadow_wr, shadow_we;
  logic                         wr_err_nxt, cfg_err_nxt;
  logic [7:0]                   rd_mux;
  int unsigned                  addr;

  frame_tracker #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_frame_tracker (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid_i),
    .sop       (sop_i),
    .eop       (eop_i),
    .in_frame  (in_frame_o),
    .frame_cnt (frame_cnt_o),
    .sop_beat  (sop_beat),
    .eop_beat  (eop_beat)
  );

  always_comb begin
    addr      = 32'(addr_i);
    commit_wr = wr_en_i && (addr == ADDR_CTRL) && wr_data_i[0];
    shadow_wr = wr_en_i && (addr <= ADDR_BIAS);
  end

  assign pending_o     = (state == PENDING);
  assign commit_done_o = (state == APPLY);

  // A commit with a frame already open, or opening this very cycle, must wait for its eop
  always_comb begin
    state_nxt   = state;
    shadow_we   = shadow_wr;
    wr_err_nxt  = 1'b0;
    cfg_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (commit_wr) begin
          if (shadow_div == '0)              cfg_err_nxt = 1'b1;
          else if (!in_frame_o && !sop_beat) state_nxt   = APPLY;
          else                               state_nxt   = PENDING;
        end
      end
      PENDING: begin
        shadow_we  = 1'b0;
        wr_err_nxt = shadow_wr;
        if (eop_beat) state_nxt = APPLY;
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reads see the shadow state before any same-cycle write lands
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++)
      if (addr == ADDR_COEF0 + i) rd_mux = sext8(shadow_coef[i]);
    if (addr == ADDR_DIV)  rd_mux = sext8(shadow_div);
    if (addr == ADDR_BIAS) rd_mux = shadow_bias;
    if (addr == ADDR_CTRL) rd_mux = {6'b0, in_frame_o, pending_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_err_o      <= 1'b0;
      cfg_err_o     <= 1'b0;
      rd_valid_o    <= 1'b0;
      rd_data_o     <= '0;
      shadow_div    <= COEF_WIDTH'(IDENT_DIV);
      shadow_bias   <= IDENT_BIAS;
      div_coef_o    <= COEF_WIDTH'(IDENT_DIV);
      bias_factor_o <= IDENT_BIAS;
      for (int unsigned i = 0; i < NUM_TAPS; i++)
        shadow_coef[i] <= ident_coef(i);
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          coef_o[r][c] <= ident_coef(r * 3 + c);
    end else begin
      state      <= state_nxt;
      wr_err_o   <= wr_err_nxt;
      cfg_err_o  <= cfg_err_nxt;
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_mux;
      if (shadow_we) begin
        for (int unsigned i = 0; i < NUM_TAPS; i++)
          if (addr == ADDR_COEF0 + i) shadow_coef[i] <= $signed(wr_data_i[COEF_WIDTH-1:0]);
        if (addr == ADDR_DIV)  shadow_div  <= $signed(wr_data_i[COEF_WIDTH-1:0]);
        if (addr == ADDR_BIAS) shadow_bias <= wr_data_i;
      end
      if (state == APPLY) begin
        div_coef_o    <= shadow_div;
        bias_factor_o <= shadow_bias;
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            coef_o[r][c] <= shadow_coef[r * 3 + c];
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_cfg_ctrl.sv
// Directed bench for conv_filter_cfg_ctrl: register access, commit timing against
// the pixel stream, rejected writes/commits and reset while a commit is pending.
module tb_conv_filter_cfg_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en, rd_en;
  logic [3:0]        addr;
  logic [7:0]        wr_data;
  logic [7:0]        rd_data;
  logic              rd_valid, wr_err;
  logic              valid, sop, eop;
  logic signed [4:0] coef [3][3];
  logic signed [4:0] div_coef;
  logic [7:0]        bias;
  logic              pending, commit_done, cfg_err, in_frame;
  logic [15:0]       frame_cnt;

  int n_asrt = 0;
  int n_fail = 0;

  conv_filter_cfg_ctrl #(
    .COEF_WIDTH (5),
    .ADDR_WIDTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (wr_en),
    .rd_en_i       (rd_en),
    .addr_i        (addr),
    .wr_data_i     (wr_data),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .wr_err_o      (wr_err),
    .valid_i       (valid),
    .sop_i         (sop),
    .eop_i         (eop),
    .coef_o        (coef),
    .div_coef_o    (div_coef),
    .bias_factor_o (bias),
    .pending_o     (pending),
    .commit_done_o (commit_done),
    .cfg_err_o     (cfg_err),
    .in_frame_o    (in_frame),
    .frame_cnt_o   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; addr = 4'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, input int exp);
    rd_en = 1'b1; addr = 4'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk($sformatf("rd_valid@%0d", a), rd_valid, 1);
    chk($sformatf("rd_data@%0d", a), rd_data, exp);
  endtask

  task automatic beat(input logic s, input logic e);
    valid = 1'b1; sop = s; eop = e;
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic chk_kernel(input string tag, input int centre, input int other);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("%s_coef%0d%0d", tag, r, c), coef[r][c], (r == 1 && c == 1) ? centre : other);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1: reset state and identity register contents
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_in_frame", in_frame, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_commit_done", commit_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_div", div_coef, 1);
    chk("rst_bias", bias, 0);
    chk_kernel("rst", 1, 0);
    for (int a = 0; a < 12; a++) rd(a, (a == 4 || a == 9) ? 1 : 0);

    // 5: zero divisor commit is rejected
    wr(9, 0);
    wr(11, 1);
    chk("zdiv_cfg_err", cfg_err, 1);
    chk("zdiv_pending", pending, 0);
    chk("zdiv_commit_done", commit_done, 0);
    step();
    chk("zdiv_cfg_err_clr", cfg_err, 0);
    chk("zdiv_commit_done2", commit_done, 0);
    chk("zdiv_div_kept", div_coef, 1);
    rd(11, 0);

    // 2: idle-stream commit of an all -1 kernel
    for (int a = 0; a < 9; a++) wr(a, 8'hFF);
    wr(9, 9);
    wr(10, 0);
    for (int a = 0; a < 9; a++) rd(a, 8'hFF);
    rd(9, 9);
    chk_kernel("shadow_only", 1, 0);
    wr(11, 1);
    chk("idle_commit_done", commit_done, 1);
    chk("idle_pending", pending, 0);
    chk("idle_old_coef00", coef[0][0], 0);
    step();
    chk("idle_commit_done_clr", commit_done, 0);
    chk("idle_pending2", pending, 0);
    chk_kernel("idle_new", -1, -1);
    chk("idle_div", div_coef, 9);
    chk("idle_bias", bias, 0);

    // 3 + 4: commit requested inside a 64-pixel frame, shadow write rejected while pending
    wr(4, 3);
    chk("shadow_wr_active", coef[1][1], -1);
    beat(1'b1, 1'b0);
    chk("frm_in_frame", in_frame, 1);
    wr(11, 1);
    chk("frm_pending", pending, 1);
    chk("frm_no_done", commit_done, 0);
    wr(3, 2);
    chk("frm_wr_err", wr_err, 1);
    wr(11, 1);
    chk("frm_recommit_wr_err", wr_err, 0);
    chk("frm_recommit_cfg_err", cfg_err, 0);
    chk("frm_recommit_pending", pending, 1);
    for (int p = 1; p < 63; p++) begin
      beat(1'b0, 1'b0);
      chk($sformatf("frm_pend_px%0d", p), pending, 1);
      chk($sformatf("frm_coef11_px%0d", p), coef[1][1], -1);
    end
    beat(1'b0, 1'b1);
    chk("eop_commit_done", commit_done, 1);
    chk("eop_pending", pending, 0);
    chk("eop_in_frame", in_frame, 0);
    chk("eop_frame_cnt", frame_cnt, 1);
    chk("eop_coef11_old", coef[1][1], -1);
    step();
    chk("eop_commit_done_clr", commit_done, 0);
    chk("eop_coef11_new", coef[1][1], 3);
    chk("eop_coef10", coef[1][0], -1);
    rd(3, 8'hFF);
    rd(4, 8'h03);

    // 6: reset while a commit is pending mid-frame
    beat(1'b1, 1'b0);
    wr(11, 1);
    chk("r6_pending", pending, 1);
    beat(1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r6_pending_clr", pending, 0);
    chk("r6_in_frame", in_frame, 0);
    chk("r6_frame_cnt", frame_cnt, 0);
    chk_kernel("r6", 1, 0);
    chk("r6_div", div_coef, 1);
    beat(1'b0, 1'b1);
    chk("r6_eop_no_done", commit_done, 0);
    chk("r6_eop_frame_cnt", frame_cnt, 1);
    chk("r6_eop_in_frame", in_frame, 0);
    step();
    chk("r6_no_done2", commit_done, 0);
    chk("r6_coef11", coef[1][1], 1);

    // single-pixel frame, unmapped addresses, read-during-write, ctrl status, bias commit
    beat(1'b1, 1'b1);
    chk("spf_in_frame", in_frame, 0);
    chk("spf_frame_cnt", frame_cnt, 2);
    rd(12, 0);
    wr(12, 8'hFF);
    chk("unmapped_wr_err", wr_err, 0);
    rd(15, 0);
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'd10; wr_data = 8'hA5;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rw_same_old", rd_data, 0);
    rd(10, 8'hA5);
    beat(1'b1, 1'b0);
    rd(11, 8'h02);
    beat(1'b0, 1'b1);
    chk("f3_frame_cnt", frame_cnt, 3);
    wr(11, 1);
    chk("bias_commit_done", commit_done, 1);
    step();
    chk("bias_active", bias, 8'hA5);
    chk("bias_div", div_coef, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_filter_cfg_ctrl.md
Name: conv_filter_cfg_ctrl

Overview:
- Configuration controller for the RGB 3x3 convolution filter wrapper.
- A register-write port loads a shadow kernel (9 signed coefficients, divisor, bias). A commit request transfers the shadow kernel to the active outputs only at a frame boundary, so the filter never processes a frame with a torn kernel.
- Monitors the same valid/sop/eop stream that feeds the filter. Reports frame count and commit status.

Parameters:
- COEF_WIDTH, 5, signed coefficient and divisor width; must match the filter.
- ADDR_WIDTH, 4, register address width.
- CNT_WIDTH, 16, frame counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en_i  in  1  register write strobe.
- rd_en_i  in  1  register read strobe.
- addr_i  in  ADDR_WIDTH  register address.
- wr_data_i  in  8  write data; low COEF_WIDTH bits are used for coefficients and divisor.
- rd_data_o  out  8  read data, registered.
- rd_valid_o  out  1  read data valid.
- wr_err_o  out  1  one-cycle pulse: write rejected.
- valid_i  in  1  pixel valid, same as filter input.
- sop_i  in  1  start of frame, qualified by valid_i.
- eop_i  in  1  end of frame, qualified by valid_i.
- coef_o[3][3]  out  signed COEF_WIDTH  active kernel, drives filter coef.
- div_coef_o  out  signed COEF_WIDTH  active divisor.
- bias_factor_o  out  8  active bias.
- pending_o  out  1  commit waiting for a frame boundary.
- commit_done_o  out  1  one-cycle pulse when the active set is updated.
- cfg_err_o  out  1  one-cycle pulse when a commit is rejected.
- in_frame_o  out  1  a frame is currently in progress.
- frame_cnt_o  out  CNT_WIDTH  completed frames, wraps.

Behaviour:
- Register map:
  - Addresses 0..8: shadow coef[row][col], address = row*3+col.
  - Address 9: div_coef.
  - Address 10: bias.
  - Address 11: control. Write bit0=1 requests a commit. Read returns {6'b0, in_frame, pending}.
  - Addresses 12..15: writes ignored, reads return 0.
- Reset values, shadow and active alike:
  - Identity kernel: coef[1][1]=1, all other coefficients 0.
  - div_coef=1, bias=0.
  - pending=0, in_frame=0, frame_cnt=0.
  - rd_data=0, rd_valid=0, all pulses 0.
- Reset mid-frame or mid-pending discards the pending commit and restores the identity kernel.
- Reads:
  - rd_data_o and rd_valid_o are valid one cycle after rd_en_i.
  - Coefficient reads are sign-extended to 8 bits.
  - If rd_en_i and wr_en_i target the same address in the same cycle, the read returns the old value.
- Frame tracking:
  - in_frame sets on valid_i&sop_i and clears on valid_i&eop_i.
  - valid&sop&eop in the same cycle is a single-pixel frame: in_frame stays 0 and frame_cnt increments.
  - frame_cnt increments on every valid_i&eop_i and wraps to 0 at its maximum.
- FSM states: IDLE, PENDING, APPLY.
- IDLE:
  - Commit write with shadow div_coef==0: cfg_err pulse, stay in IDLE.
  - Valid commit write while in_frame=0 and no valid&sop in the same cycle: go to APPLY.
  - Valid commit write otherwise: go to PENDING.
- PENDING:
  - pending_o=1.
  - Shadow writes to addresses 0..10 are rejected: wr_err pulse, shadow unchanged.
  - A repeated commit write is ignored, with no error.
  - On valid_i&eop_i: go to APPLY.
- APPLY (one cycle):
  - Active registers <= shadow.
  - commit_done pulses in this cycle; active outputs take the new values on the following edge.
  - Return to IDLE.
- Commit latency:
  - Idle stream: new active values are visible 2 cycles after the commit write.
  - Mid-frame: new active values are visible 2 cycles after the eop beat.
- Active outputs change only via APPLY or reset. Their values are stable throughout any frame.
- Shadow writes in IDLE take effect next cycle. Active outputs are unaffected.
- Non-valid cycles never change frame state.
- An eop without a preceding sop still increments frame_cnt and clears in_frame. This is tolerant behaviour, not an error.

Decomposition:
- Package conv_cfg_pkg holds:
  - Register address localparams: ADDR_COEF0=0, ADDR_DIV=9, ADDR_BIAS=10, ADDR_CTRL=11.
  - FSM state enum cfg_state_t {IDLE, PENDING, APPLY}.
  - Identity kernel reset constant.
- One natural sub-module: frame_tracker. It owns in_frame, frame_cnt and an eop strobe, and is reusable by other video blocks.
- The register file and FSM stay in the top module.

Test Plan:
1. Reset, then read addresses 0..11 -> coef reads 0 except address 4 = 0x01; address 9 = 0x01; address 10 = 0x00; address 11 = 0x00; coef_o is the identity kernel.
2. Idle stream: write coef addresses 0..8 = -1 (0xFF, reads back 0xFF), div = 9, bias = 0, then write ctrl = 1 at cycle T -> commit_done at T+1, coef_o all -1 and div_coef_o = 9 at T+2, pending_o never asserted.
3. Commit issued after sop of a 64-pixel frame -> pending_o=1 until the eop beat, coef_o unchanged through the frame, commit_done one cycle after eop, frame_cnt_o = 1.
4. While PENDING, write address 3 = 2 -> wr_err_o pulse; after commit, reading address 3 returns the pre-pending value.
5. Set div = 0, then commit -> cfg_err_o pulse, state stays IDLE, active div_coef_o remains 1.
6. Assert reset while PENDING mid-frame -> next cycle pending_o = 0, in_frame_o = 0, identity kernel on outputs, and a later eop produces no commit_done.
